// File: rtl/partial_word_packer.sv
// Byte-to-word packer: pairs a high byte with the following low byte into a
// {high, low} word and queues completed words in a small output FIFO.
module partial_word_packer #(
  parameter int BYTE_W     = 8,
  parameter int WORD_DEPTH = 2,
  parameter int TIMEOUT    = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [BYTE_W-1:0] data_in,
  input  logic              first,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [2*BYTE_W-1:0] data_out,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic              status_clr,
  output logic [3:0]        status,
  output logic              ready
);

  localparam int CW    = $clog2(TIMEOUT);
  localparam int PW    = $clog2(WORD_DEPTH);
  localparam int CNT_W = PW + 1;

  typedef enum logic {EXPECT_HI = 1'b0, EXPECT_LO = 1'b1} state_t;

  state_t              state_q;
  logic [BYTE_W-1:0]   hold_q;
  logic [CW-1:0]       tmo_cnt_q;
  logic                ready_q;
  logic [2*BYTE_W-1:0] mem_q [WORD_DEPTH];
  logic [PW-1:0]       wr_ptr_q;
  logic [PW-1:0]       rd_ptr_q;
  logic [CNT_W-1:0]    count_q;
  logic [CNT_W-1:0]    count_d;
  logic                tmo_flag_q;
  logic                sync_flag_q;

  logic fifo_full_s;
  logic accept_s;
  logic push_s;
  logic pop_s;
  logic timeout_s;
  logic sync_err_s;

  assign fifo_full_s = (count_q == CNT_W'(WORD_DEPTH));
  assign in_ready    = enable && ready_q && ((state_q == EXPECT_HI) || !fifo_full_s);
  assign accept_s    = in_valid && in_ready;
  assign push_s      = accept_s && (state_q == EXPECT_LO) && !first;
  assign out_valid   = (count_q != CNT_W'(0));
  assign pop_s       = out_valid && out_ready;
  // Only an idle, enabled cycle in EXPECT_LO can expire the held byte; an accepted low byte wins.
  assign timeout_s   = (state_q == EXPECT_LO) && enable && !accept_s &&
                       (tmo_cnt_q == CW'(TIMEOUT - 1));
  assign sync_err_s  = accept_s && (((state_q == EXPECT_HI) && !first) ||
                                    ((state_q == EXPECT_LO) && first));

  assign data_out = mem_q[rd_ptr_q];
  assign ready    = ready_q && enable;
  assign status   = {sync_flag_q, tmo_flag_q, fifo_full_s, (state_q == EXPECT_LO)};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= EXPECT_HI;
      hold_q    <= '0;
      tmo_cnt_q <= '0;
    end else begin
      case (state_q)
        EXPECT_HI: begin
          if (accept_s && first) begin
            hold_q    <= data_in;
            tmo_cnt_q <= '0;
            state_q   <= EXPECT_LO;
          end
        end
        EXPECT_LO: begin
          if (accept_s) begin
            if (first) begin
              hold_q    <= data_in;
              tmo_cnt_q <= '0;
            end else begin
              state_q <= EXPECT_HI;
            end
          end else if (enable) begin
            if (timeout_s) begin
              state_q <= EXPECT_HI;
            end else begin
              tmo_cnt_q <= tmo_cnt_q + CW'(1);
            end
          end
        end
        default: state_q <= EXPECT_HI;
      endcase
    end
  end

  always_comb begin
    count_d = count_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage is cleared on reset so data_out reads zero until the first word lands.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < WORD_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_s) begin
        mem_q[wr_ptr_q] <= {hold_q, data_in};
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ready_q     <= 1'b0;
      tmo_flag_q  <= 1'b0;
      sync_flag_q <= 1'b0;
    end else begin
      ready_q     <= 1'b1;
      tmo_flag_q  <= timeout_s  || (tmo_flag_q  && !status_clr);
      sync_flag_q <= sync_err_s || (sync_flag_q && !status_clr);
    end
  end

endmodule

// File: tb/tb_partial_word_packer.sv
// Self-checking bench for partial_word_packer: a scoreboard queue holds the
// words expected on the output port, directed sequences exercise the FSM.
module tb_partial_word_packer;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [7:0]  data_in;
  logic        first;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] data_out;
  logic        out_valid;
  logic        out_ready;
  logic        status_clr;
  logic [3:0]  status;
  logic        ready;

  int n_chk  = 0;
  int n_pass = 0;
  logic [15:0] sb_q [$];

  partial_word_packer #(.BYTE_W(8), .WORD_DEPTH(2), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .enable(enable), .data_in(data_in),
    .first(first), .in_valid(in_valid), .in_ready(in_ready),
    .data_out(data_out), .out_valid(out_valid), .out_ready(out_ready),
    .status_clr(status_clr), .status(status), .ready(ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic f);
    int n;
    data_in  = b;
    first    = f;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) chk("send_wait", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    out_ready = 1'b1;
    n = 0;
    while (out_valid && n < 20) begin
      n++;
      tick();
    end
    chk("drain_done", 32'(out_valid), 32'd0);
  endtask

  task automatic pulse_clr();
    status_clr = 1'b1;
    tick();
    status_clr = 1'b0;
  endtask

  // Scoreboard: every word leaving the FIFO must match the oldest expected word.
  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      if (sb_q.size() == 0) chk("unexpected_word", 32'(data_out), 32'hFFFF_FFFF);
      else chk("word", 32'(data_out), 32'(sb_q.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; enable = 1'b1; data_in = 8'h00; first = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; status_clr = 1'b0;
    #12;
    chk("rst_ready",    32'(ready),     32'd0);
    chk("rst_in_ready", 32'(in_ready),  32'd0);
    chk("rst_out_valid",32'(out_valid), 32'd0);
    chk("rst_data_out", 32'(data_out),  32'd0);
    chk("rst_status",   32'(status),    32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rel_ready_low", 32'(ready), 32'd0);
    tick();
    chk("rel_ready",    32'(ready),    32'd1);
    chk("rel_in_ready", 32'(in_ready), 32'd1);

    // Basic pair
    out_ready = 1'b1;
    send(8'hA5, 1'b1);
    sb_q.push_back(16'hA53C);
    send(8'h3C, 1'b0);
    chk("basic_valid", 32'(out_valid), 32'd1);
    chk("basic_data",  32'(data_out),  32'h0000_A53C);
    tick();
    chk("basic_valid_1cyc", 32'(out_valid), 32'd0);

    // Backpressure
    out_ready = 1'b0;
    send(8'h11, 1'b1); sb_q.push_back(16'h1122); send(8'h22, 1'b0);
    send(8'h33, 1'b1); sb_q.push_back(16'h3344); send(8'h44, 1'b0);
    chk("bp_full", 32'(status[1]), 32'd1);
    data_in = 8'h55; first = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    chk("bp_hi_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("bp_held",     32'(status[0]), 32'd1);
    chk("bp_blocked",  32'(in_ready),  32'd0);
    tick();
    chk("bp_blocked2", 32'(in_ready),  32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_reopen", 32'(in_ready), 32'd1);
    sb_q.push_back(16'h5566);
    send(8'h66, 1'b0);
    drain();
    chk("bp_sb_empty", 32'(sb_q.size()), 32'd0);

    // Timeout, then low byte on the last allowed cycle
    send(8'hAB, 1'b1);
    repeat (3) tick();
    chk("tmo_not_yet", 32'(status[2]), 32'd0);
    tick();
    chk("tmo_flag",  32'(status[2]), 32'd1);
    chk("tmo_held",  32'(status[0]), 32'd0);
    chk("tmo_nopush",32'(out_valid), 32'd0);
    pulse_clr();
    chk("tmo_clr", 32'(status[2]), 32'd0);
    send(8'hCD, 1'b1);
    repeat (3) tick();
    sb_q.push_back(16'hCDEF);
    send(8'hEF, 1'b0);
    chk("tmo_lo_wins_flag", 32'(status[2]), 32'd0);
    chk("tmo_lo_wins_push", 32'(out_valid), 32'd1);
    tick();

    // Sync errors
    send(8'h77, 1'b0);
    chk("sync_flag", 32'(status[3]), 32'd1);
    chk("sync_drop", 32'(status[0]), 32'd0);
    send(8'h10, 1'b1);
    send(8'h20, 1'b1);
    sb_q.push_back(16'h2030);
    send(8'h30, 1'b0);
    tick();
    pulse_clr();
    chk("sync_clr", 32'(status[3]), 32'd0);
    status_clr = 1'b1;
    send(8'h55, 1'b0);
    status_clr = 1'b0;
    chk("sync_set_wins", 32'(status[3]), 32'd1);
    pulse_clr();
    chk("sb_empty_mid", 32'(sb_q.size()), 32'd0);

    // Reset mid-operation
    out_ready = 1'b0;
    send(8'h01, 1'b1); sb_q.push_back(16'h0102); send(8'h02, 1'b0);
    send(8'h03, 1'b1); sb_q.push_back(16'h0304); send(8'h04, 1'b0);
    send(8'h05, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_status",    32'(status),    32'd0);
    chk("mid_rst_ready",     32'(ready),     32'd0);
    sb_q.delete();
    @(negedge clk);
    reset = 1'b1;
    tick();
    chk("mid_rel_ready", 32'(ready), 32'd1);
    out_ready = 1'b1;
    send(8'h06, 1'b1);
    sb_q.push_back(16'h0607);
    send(8'h07, 1'b0);
    tick();
    chk("mid_sb_empty", 32'(sb_q.size()), 32'd0);

    // Enable gating while a high byte is held
    out_ready = 1'b0;
    send(8'h08, 1'b1); sb_q.push_back(16'h0809); send(8'h09, 1'b0);
    send(8'h0A, 1'b1);
    enable = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("en_in_ready", 32'(in_ready), 32'd0);
      chk("en_ready",    32'(ready),    32'd0);
    end
    chk("en_no_tmo",  32'(status[2]), 32'd0);
    chk("en_held",    32'(status[0]), 32'd1);
    chk("en_popped",  32'(out_valid), 32'd0);
    enable = 1'b1;
    sb_q.push_back(16'h0A0B);
    send(8'h0B, 1'b0);
    drain();
    chk("final_sb_empty", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
